// File: rtl/cmd_deserializer_if.sv
// Command-side bundle of cmd_deserializer: serial input, the handshake, decoded fields and
// status pulses. master = deserializer, slave = consumer/driver of the serial line.
interface cmd_deserializer_if #(
  parameter int unsigned INBITS = 8,
  parameter int unsigned WIDTH  = 8
);
  logic              commandInput;
  logic              BitValid;
  logic              CmdReady;
  logic              ValidCmd;
  logic              RW;
  logic              ConfigDiv;
  logic [3:0]        Sel;
  logic [31:0]       Din;
  logic [WIDTH-1:0]  Addr;
  logic [INBITS-1:0] inA;
  logic [INBITS-1:0] inB;
  logic              ParErr;
  logic              Overrun;
  logic              Timeout;

  modport master (
    input  commandInput, BitValid, CmdReady,
    output ValidCmd, RW, ConfigDiv, Sel, Din, Addr, inA, inB, ParErr, Overrun, Timeout
  );

  modport slave (
    output commandInput, BitValid, CmdReady,
    input  ValidCmd, RW, ConfigDiv, Sel, Din, Addr, inA, inB, ParErr, Overrun, Timeout
  );
endinterface

// File: rtl/cmd_deserializer.sv
// Serial command receiver: start/op/payload/parity framing, even-parity check, one-deep output
// buffer with ValidCmd/CmdReady handshake. Optional in-frame idle timeout via CMD_TIMEOUT_EN.
module cmd_deserializer #(
  parameter int unsigned INBITS  = 8,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                Clk,
  input logic                Reset,
  cmd_deserializer_if.master bus
);
  localparam int unsigned WR_LEN  = WIDTH + 32;
  localparam int unsigned ALU_LEN = 4 + 2 * INBITS;
  localparam int unsigned MAXP    = (WR_LEN > ALU_LEN) ? WR_LEN : ALU_LEN;
  localparam int unsigned CW      = $clog2(MAXP);

  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_PAYLOAD, S_PARITY} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        op, op_n;
  logic [MAXP-1:0]   sr, sr_n;
  logic              par, par_n;
  logic              frame_done, parity_bad, load;

  logic              valid_q, rw_q, cfg_q, parerr_q, overrun_q;
  logic [3:0]        sel_q, dec_sel;
  logic [31:0]       din_q, dec_din;
  logic [WIDTH-1:0]  addr_q, dec_addr;
  logic [INBITS-1:0] a_q, b_q, dec_a, dec_b;
  logic              dec_rw, dec_cfg;

  // Payload length minus one, so the counter ends the payload when it hits zero.
  function automatic logic [CW-1:0] last_idx(input logic [1:0] o);
    case (o)
      2'b00:   return CW'(WR_LEN - 1);
      2'b01:   return CW'(WIDTH - 1);
      2'b10:   return CW'(31);
      default: return CW'(ALU_LEN - 1);
    endcase
  endfunction

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt, idle_n;
  logic          to_q, to_n;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    op_n       = op;
    sr_n       = sr;
    par_n      = par;
    frame_done = 1'b0;
    parity_bad = par ^ bus.commandInput;
    if (bus.BitValid) begin
      case (state)
        S_IDLE: if (bus.commandInput) begin
          state_n = S_OPCODE;
          cnt_n   = '0;
          par_n   = 1'b0;
        end
        S_OPCODE: begin
          op_n  = {op[0], bus.commandInput};
          par_n = par ^ bus.commandInput;
          if (cnt == CW'(1)) begin
            state_n = S_PAYLOAD;
            cnt_n   = last_idx(op_n);
          end else begin
            cnt_n = CW'(1);
          end
        end
        S_PAYLOAD: begin
          sr_n  = {sr[MAXP-2:0], bus.commandInput};
          par_n = par ^ bus.commandInput;
          if (cnt == '0) state_n = S_PARITY;
          else           cnt_n   = cnt - CW'(1);
        end
        default: begin
          state_n    = S_IDLE;
          frame_done = 1'b1;
        end
      endcase
    end
`ifdef CMD_TIMEOUT_EN
    idle_n = idle_cnt;
    to_n   = 1'b0;
    if (state == S_IDLE || bus.BitValid) begin
      idle_n = '0;
    end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
      idle_n  = '0;
      to_n    = 1'b1;
      state_n = S_IDLE;
    end else begin
      idle_n = idle_cnt + IW'(1);
    end
`endif
  end

  // A completed frame loads if the buffer is empty or is being accepted on this same edge.
  assign load = frame_done && !parity_bad && (!valid_q || bus.CmdReady);

  always_comb begin
    dec_rw   = 1'b0;
    dec_cfg  = 1'b0;
    dec_sel  = '0;
    dec_din  = '0;
    dec_addr = '0;
    dec_a    = '0;
    dec_b    = '0;
    case (op)
      2'b00: begin
        dec_rw   = 1'b1;
        dec_addr = sr[WR_LEN-1:32];
        dec_din  = sr[31:0];
      end
      2'b01: dec_addr = sr[WIDTH-1:0];
      2'b10: begin
        dec_cfg = 1'b1;
        dec_din = sr[31:0];
      end
      default: begin
        dec_sel = sr[ALU_LEN-1 -: 4];
        dec_a   = sr[2*INBITS-1 -: INBITS];
        dec_b   = sr[INBITS-1:0];
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op        <= '0;
      sr        <= '0;
      par       <= 1'b0;
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      cfg_q     <= 1'b0;
      sel_q     <= '0;
      din_q     <= '0;
      addr_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      parerr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op        <= op_n;
      sr        <= sr_n;
      par       <= par_n;
      parerr_q  <= frame_done && parity_bad;
      overrun_q <= frame_done && !parity_bad && valid_q && !bus.CmdReady;
      if (load) begin
        valid_q <= 1'b1;
        rw_q    <= dec_rw;
        cfg_q   <= dec_cfg;
        sel_q   <= dec_sel;
        din_q   <= dec_din;
        addr_q  <= dec_addr;
        a_q     <= dec_a;
        b_q     <= dec_b;
      end else if (valid_q && bus.CmdReady) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idle_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      idle_cnt <= idle_n;
      to_q     <= to_n;
    end
  end
  assign bus.Timeout = to_q;
`else
  // TIMEOUT has no effect when the timeout feature is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.Timeout    = 1'b0;
`endif

  assign bus.ValidCmd  = valid_q;
  assign bus.RW        = rw_q;
  assign bus.ConfigDiv = cfg_q;
  assign bus.Sel       = sel_q;
  assign bus.Din       = din_q;
  assign bus.Addr      = addr_q;
  assign bus.inA       = a_q;
  assign bus.inB       = b_q;
  assign bus.ParErr    = parerr_q;
  assign bus.Overrun   = overrun_q;
endmodule

// File: tb/tb_cmd_deserializer.sv
// Self-checking bench for cmd_deserializer: directed spec scenarios plus random frames checked
// against a frame-level reference model (bit lists, ones count, one-deep command buffer).
`timescale 1ns/1ps
module tb_cmd_deserializer;
  localparam int unsigned INBITS  = 8;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 64;

  logic clk;
  logic rst;

  cmd_deserializer_if #(.INBITS(INBITS), .WIDTH(WIDTH)) bus ();

  cmd_deserializer #(.INBITS(INBITS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rw;
    logic              cfg;
    logic [3:0]        sel;
    logic [31:0]       din;
    logic [WIDTH-1:0]  addr;
    logic [INBITS-1:0] a;
    logic [INBITS-1:0] b;
  } cmd_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  cmd_t m_cmd, f_cmd;
  bit   m_valid;
  bit   f_ok;
  bit   bits_q[$];
  int   rmode;
  bit   exp_to;
  bit   exp_pe, exp_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model at the edge, then check outputs.
  task automatic drive(input logic b, input logic v, input bit last);
    logic r;
    case (rmode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      2:       r = 1'($urandom);
      default: r = last;
    endcase
    bus.commandInput = b;
    bus.BitValid     = v;
    bus.CmdReady     = r;
    @(posedge clk);
    exp_pe = 1'b0;
    exp_ov = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
    end else if (last) begin
      if (!f_ok) begin
        exp_pe = 1'b1;
        if (m_valid && r) m_valid = 1'b0;
      end else if (m_valid && !r) begin
        exp_ov = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_cmd   = f_cmd;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    #1;
    chk("ValidCmd", 32'(bus.ValidCmd), 32'(m_valid));
    chk("ParErr",   32'(bus.ParErr),   32'(exp_pe));
    chk("Overrun",  32'(bus.Overrun),  32'(exp_ov));
    chk("Timeout",  32'(bus.Timeout),  32'(exp_to));
    if (m_valid) begin
      chk("RW",        32'(bus.RW),        32'(m_cmd.rw));
      chk("ConfigDiv", 32'(bus.ConfigDiv), 32'(m_cmd.cfg));
      chk("Sel",       32'(bus.Sel),       32'(m_cmd.sel));
      chk("Din",       bus.Din,            m_cmd.din);
      chk("Addr",      32'(bus.Addr),      32'(m_cmd.addr));
      chk("inA",       32'(bus.inA),       32'(m_cmd.a));
      chk("inB",       32'(bus.inB),       32'(m_cmd.b));
    end
  endtask

  task automatic push_field(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(val[i]);
  endtask

  task automatic build_frame(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] din,
                             input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                             input bit bad);
    int ones;
    bits_q.delete();
    bits_q.push_back(1'b1);
    bits_q.push_back(op[1]);
    bits_q.push_back(op[0]);
    f_cmd = '0;
    case (op)
      2'b00: begin
        push_field(addr, WIDTH); push_field(din, 32);
        f_cmd.rw = 1'b1; f_cmd.addr = addr[WIDTH-1:0]; f_cmd.din = din;
      end
      2'b01: begin
        push_field(addr, WIDTH);
        f_cmd.addr = addr[WIDTH-1:0];
      end
      2'b10: begin
        push_field(din, 32);
        f_cmd.cfg = 1'b1; f_cmd.din = din;
      end
      default: begin
        push_field(32'(sel), 4); push_field(a, INBITS); push_field(b, INBITS);
        f_cmd.sel = sel; f_cmd.a = a[INBITS-1:0]; f_cmd.b = b[INBITS-1:0];
      end
    endcase
    ones = 0;
    for (int i = 1; i < bits_q.size(); i++) if (bits_q[i]) ones++;
    bits_q.push_back(((ones % 2) == 1) ^ bad);
    f_ok = !bad;
  endtask

  // gap: 0 none, 1 an idle cycle before every bit, 2 random idle cycles.
  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      if (gap == 1 || (gap == 2 && ($urandom % 3) == 0))
        drive(1'($urandom), 1'b0, 1'b0);
      drive(bits_q[i], 1'b1, i == bits_q.size() - 1);
    end
  endtask

  task automatic send_frame(input int gap);
    send_range(0, bits_q.size() - 1, gap);
  endtask

  // Qualified zeros in IDLE must be ignored, so idle traffic mixes BitValid levels.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.commandInput = 1'b0;
    bus.BitValid = 1'b0;
    bus.CmdReady = 1'b0;
    m_cmd = '0; f_cmd = '0; m_valid = 1'b0; f_ok = 1'b1;
    rmode = 0; exp_to = 1'b0;

    reset_cycles(3);
    chk("rst_RW",   32'(bus.RW),        32'd0);
    chk("rst_Cfg",  32'(bus.ConfigDiv), 32'd0);
    chk("rst_Sel",  32'(bus.Sel),       32'd0);
    chk("rst_Din",  bus.Din,            32'd0);
    chk("rst_Addr", 32'(bus.Addr),      32'd0);
    chk("rst_inA",  32'(bus.inA),       32'd0);
    chk("rst_inB",  32'(bus.inB),       32'd0);

    // WRITE with a ready consumer: one-cycle ValidCmd
    rmode = 1;
    build_frame(2'b00, 32'hA5, 32'hDEADBEEF, 4'h0, 32'h0, 32'h0, 1'b0);
    send_frame(0);
    idle(3);

    // ALU held for 5 cycles, then accepted
    rmode = 0;
    build_frame(2'b11, 32'h0, 32'h0, 4'h3, 32'h0F, 32'hF0, 1'b0);
    send_frame(0);
    idle(5);
    rmode = 1;
    idle(2);

    // Bad parity on the same ALU frame
    rmode = 0;
    build_frame(2'b11, 32'h0, 32'h0, 4'h3, 32'h0F, 32'hF0, 1'b1);
    send_frame(0);
    idle(2);

    // Overrun: READ pending, CONFIG completes
    build_frame(2'b01, 32'h11, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    send_frame(0);
    build_frame(2'b10, 32'h0, 32'h4, 4'h0, 32'h0, 32'h0, 1'b0);
    send_frame(0);
    idle(2);
    chk("ovr_Addr", 32'(bus.Addr), 32'h11);

    // Accept coinciding with completion of the next frame
    rmode = 3;
    build_frame(2'b10, 32'h0, 32'h12345678, 4'h0, 32'h0, 32'h0, 1'b0);
    send_frame(0);
    rmode = 1;
    idle(2);

    // WRITE with a gap before every bit
    build_frame(2'b00, 32'h3C, 32'hCAFEF00D, 4'h0, 32'h0, 32'h0, 1'b0);
    send_frame(1);
    idle(2);

    // Reset mid-payload, then a clean frame
    build_frame(2'b00, 32'h77, 32'h01020304, 4'h0, 32'h0, 32'h0, 1'b0);
    send_range(0, 12, 0);
    reset_cycles(1);
    send_frame(0);
    idle(2);

    // Reset while a command waits for acceptance
    rmode = 0;
    build_frame(2'b01, 32'hEE, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    send_frame(0);
    idle(2);
    reset_cycles(1);
    chk("rstpend_Valid", 32'(bus.ValidCmd), 32'd0);
    rmode = 1;

    // Long stall after the op bits
    build_frame(2'b00, 32'h5A, 32'h89ABCDEF, 4'h0, 32'h0, 32'h0, 1'b0);
    send_range(0, 2, 0);
`ifdef CMD_TIMEOUT_EN
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) drive(1'b0, 1'b0, 1'b0);
    exp_to = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    exp_to = 1'b0;
    idle(2);
    send_frame(0);
`else
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b0);
    send_range(3, bits_q.size() - 1, 0);
`endif
    idle(2);

    // Random frames, gaps, parity errors and consumer back-pressure
    rmode = 2;
    for (int n = 0; n < 40; n++) begin
      build_frame(2'($urandom), $urandom, $urandom, 4'($urandom), $urandom, $urandom,
                  ($urandom % 8) == 0);
      send_frame(2);
      idle(int'($urandom % 4));
    end
    rmode = 1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
